// File: rtl/delay_measure_ctrl.sv
// Delay-path measurement controller: launches path toggles, timestamps the synchronized
// return against the datapath counter and keeps last/min/max/sum statistics per run.
`timescale 1ns/1ps
module delay_measure_ctrl #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int SAMP_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SAMP_W-1:0]       num_samples,
    input  logic [CNT_W-1:0]        count_in,
    input  logic                    path_result,
    output logic                    path_in,
    output logic                    ld,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [CNT_W-1:0]        last_count,
    output logic [CNT_W-1:0]        min_count,
    output logic [CNT_W-1:0]        max_count,
    output logic [CNT_W+SAMP_W-1:0] sum_count,
    output logic [SAMP_W-1:0]       sample_idx
);

    localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int ELAP_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, WAIT, RECORD, DONE} stateT;

    stateT                    state, nextState;
    logic [SYNC_STAGES-1:0]   syncReg;
    logic                     rs;
    logic                     baseline;
    logic                     pathLevel;
    logic [CNT_W-1:0]         t0, t1;
    logic [SET_W-1:0]         settleCnt;
    logic [ELAP_W-1:0]        elapsed;
    logic                     sampleValid;
    logic [SAMP_W-1:0]        targetSamples;
    logic [SAMP_W-1:0]        sampleIdxReg;
    logic [SAMP_W-1:0]        idxNext;
    logic [CNT_W-1:0]         lastReg, minReg, maxReg;
    logic [CNT_W+SAMP_W-1:0]  sumReg;
    logic                     timeoutReg;
    logic                     settleLast, arrived, timedOut;
    logic [CNT_W-1:0]         rawDelay, measDelay;

    // Only the last synchronizer stage is ever looked at; path_result is fully asynchronous.
    always_ff @(posedge clk) begin
        if (rst)
            syncReg <= '0;
        else
            syncReg <= {syncReg[SYNC_STAGES-2:0], path_result};
    end

    assign rs         = syncReg[SYNC_STAGES-1];
    assign settleLast = (settleCnt == SET_W'(SETTLE_CYC - 1));
    assign arrived    = (rs != baseline);
    assign timedOut   = (elapsed == ELAP_W'(TIMEOUT_CYC));
    assign idxNext    = sampleIdxReg + 1'b1;

    // Modular difference handles counter wrap; the synchronizer latency is removed, floored at zero.
    assign rawDelay  = t1 - t0;
    assign measDelay = (rawDelay > CNT_W'(SYNC_STAGES)) ? (rawDelay - CNT_W'(SYNC_STAGES)) : '0;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = SETTLE;
            SETTLE:  if (settleLast) nextState = LAUNCH;
            LAUNCH:  nextState = WAIT;
            WAIT:    if (arrived || timedOut) nextState = RECORD;
            RECORD:  nextState = (idxNext == targetSamples) ? DONE : SETTLE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baseline      <= 1'b0;
            pathLevel     <= 1'b0;
            t0            <= '0;
            t1            <= '0;
            settleCnt     <= '0;
            elapsed       <= '0;
            sampleValid   <= 1'b0;
            targetSamples <= '0;
            sampleIdxReg  <= '0;
            lastReg       <= '0;
            minReg        <= '1;
            maxReg        <= '0;
            sumReg        <= '0;
            timeoutReg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        targetSamples <= (num_samples == '0) ? SAMP_W'(1) : num_samples;
                        sampleIdxReg  <= '0;
                        lastReg       <= '0;
                        minReg        <= '1;
                        maxReg        <= '0;
                        sumReg        <= '0;
                        timeoutReg    <= 1'b0;
                        settleCnt     <= '0;
                    end
                end
                SETTLE: begin
                    settleCnt <= settleCnt + 1'b1;
                    if (settleLast) baseline <= rs;
                end
                LAUNCH: begin
                    pathLevel <= ~pathLevel;
                    t0        <= count_in;
                    elapsed   <= '0;
                end
                WAIT: begin
                    elapsed <= elapsed + 1'b1;
                    if (arrived) begin
                        t1          <= count_in;
                        sampleValid <= 1'b1;
                    end else if (timedOut) begin
                        sampleValid <= 1'b0;
                        timeoutReg  <= 1'b1;
                    end
                end
                RECORD: begin
                    if (sampleValid) begin
                        lastReg <= measDelay;
                        if (measDelay < minReg) minReg <= measDelay;
                        if (measDelay > maxReg) maxReg <= measDelay;
                        sumReg <= sumReg + {{SAMP_W{1'b0}}, measDelay};
                    end else begin
                        lastReg <= '1;
                    end
                    sampleIdxReg <= idxNext;
                    settleCnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign path_in    = pathLevel;
    assign ld         = (state != IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign timeout    = timeoutReg;
    assign last_count = lastReg;
    assign min_count  = minReg;
    assign max_count  = maxReg;
    assign sum_count  = sumReg;
    assign sample_idx = sampleIdxReg;

endmodule

// File: tb/tb_delay_measure_ctrl.sv
// Bench for delay_measure_ctrl: counter and delay-path models drive the DUT, a
// per-run reference computes the expected statistics from the programmed delays.
`timescale 1ns/1ps
module tb_delay_measure_ctrl;

    localparam int CNT_W       = 32;
    localparam int SAMP_W      = 8;
    localparam int SETTLE_CYC  = 16;
    localparam int TIMEOUT_CYC = 50;
    localparam int RUN_LIMIT   = 5000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [SAMP_W-1:0]       numSamples;
    logic [CNT_W-1:0]        countIn = '0;
    logic                    pathResult = 1'b0;
    logic                    pathIn, ld, busy, done, timeout;
    logic [CNT_W-1:0]        lastCount, minCount, maxCount;
    logic [CNT_W+SAMP_W-1:0] sumCount;
    logic [SAMP_W-1:0]       sampleIdx;

    logic             presetReq = 1'b0;
    logic [CNT_W-1:0] presetVal = '0;
    int               delayTab [0:1023];
    int               launchNo = 0;
    int               doneCount = 0;
    logic             prevPathIn = 1'b0;
    bit               pend = 1'b0;
    int               remain = 0;
    logic [CNT_W-1:0] lastAtIdx2 = '0;
    int               passCount = 0;
    int               checkCount = 0;
    int               failCount = 0;

    delay_measure_ctrl #(
        .CNT_W(CNT_W), .SYNC_STAGES(2), .SETTLE_CYC(SETTLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .SAMP_W(SAMP_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(numSamples),
        .count_in(countIn), .path_result(pathResult), .path_in(pathIn), .ld(ld),
        .busy(busy), .done(done), .timeout(timeout), .last_count(lastCount),
        .min_count(minCount), .max_count(maxCount), .sum_count(sumCount),
        .sample_idx(sampleIdx)
    );

    always #5 clk = ~clk;

    // Datapath counter: registered, free-runs while ld is high, can be preset by the bench.
    always @(posedge clk) begin
        if (presetReq)
            countIn <= presetVal;
        else if (ld)
            countIn <= countIn + 1;
    end

    // Delay path: launch n uses delayTab[n]; 0 means the path never answers. A table
    // value D makes path_result toggle D-1 edges after the path_in edge, so that the
    // counter span seen across the two synchronizer flops is D+2 and the report is D.
    always @(posedge clk) begin
        int d;
        prevPathIn <= pathIn;
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                if (remain == 0) begin
                    pathResult <= ~pathResult;
                    pend       <= 1'b0;
                end else begin
                    remain <= remain - 1;
                end
            end
            if (pathIn != prevPathIn) begin
                d = (launchNo < 1024) ? delayTab[launchNo] : 0;
                launchNo <= launchNo + 1;
                if (d == 2) begin
                    pathResult <= ~pathResult;
                end else if (d > 2) begin
                    pend   <= 1'b1;
                    remain <= d - 3;
                end
            end
        end
        if (done) doneCount <= doneCount + 1;
        if (sampleIdx == 8'd2) lastAtIdx2 <= lastCount;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".pathIn"}, pathIn, 0);
        checkOutput({tag, ".ld"}, ld, 0);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".done"}, done, 0);
        checkOutput({tag, ".timeout"}, timeout, 0);
        checkOutput({tag, ".sampleIdx"}, sampleIdx, 0);
        checkOutput({tag, ".last"}, lastCount, 0);
        checkOutput({tag, ".min"}, minCount, 64'hFFFF_FFFF);
        checkOutput({tag, ".max"}, maxCount, 0);
        checkOutput({tag, ".sum"}, sumCount, 0);
    endtask

    // One run: the expected results come straight from the delay table entries for it.
    task automatic applyStimulus(input string tag, input logic [SAMP_W-1:0] n, input bit holdStart);
        int               base, doneBase, effN, d;
        logic [CNT_W-1:0] expLast, expMin, expMax;
        logic [39:0]      expSum;
        logic             expTo, startPath;
        bit               finished;
        base      = launchNo;
        doneBase  = doneCount;
        startPath = pathIn;
        effN      = (n == 0) ? 1 : int'(n);
        expLast = '0; expMin = '1; expMax = '0; expSum = '0; expTo = 1'b0;
        for (int i = 0; i < effN; i++) begin
            d = delayTab[base + i];
            if (d >= 2) begin
                expLast = CNT_W'(d);
                if (CNT_W'(d) < expMin) expMin = CNT_W'(d);
                if (CNT_W'(d) > expMax) expMax = CNT_W'(d);
                expSum = expSum + 40'(d);
            end else begin
                expLast = '1;
                expTo   = 1'b1;
            end
        end
        numSamples = n;
        start      = 1'b1;
        tick();
        if (!holdStart) start = 1'b0;
        checkOutput({tag, ".busyAfterStart"}, busy, 1);
        finished = 1'b0;
        for (int c = 0; c < RUN_LIMIT && !finished; c++) begin
            if (doneCount != doneBase) finished = 1'b1;
            else tick();
        end
        start = 1'b0;
        checkOutput({tag, ".runFinished"}, finished, 1);
        tick();
        tick();
        checkOutput({tag, ".doneCount"}, doneCount - doneBase, 1);
        checkOutput({tag, ".busyAfter"}, busy, 0);
        checkOutput({tag, ".sampleIdx"}, sampleIdx, effN);
        checkOutput({tag, ".launches"}, launchNo - base, effN);
        checkOutput({tag, ".pathIn"}, pathIn, startPath ^ ((effN % 2) != 0));
        checkOutput({tag, ".last"}, lastCount, expLast);
        checkOutput({tag, ".min"}, minCount, expMin);
        checkOutput({tag, ".max"}, maxCount, expMax);
        checkOutput({tag, ".sum"}, sumCount, expSum);
        checkOutput({tag, ".timeout"}, timeout, expTo);
    endtask

    initial begin
        int doneBase;
        rst        = 1'b1;
        start      = 1'b0;
        numSamples = '0;
        repeat (3) tick();
        checkResetState("powerOnReset");
        rst = 1'b0;
        tick();

        // Abort a run in the middle of WAIT with a slow path, then restart immediately.
        delayTab[launchNo] = 35;
        numSamples = 8'd4;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (SETTLE_CYC + 6) tick();
        checkOutput("midRun.busy", busy, 1);
        doneBase = doneCount;
        rst = 1'b1;
        repeat (3) tick();
        checkResetState("midRunReset");
        checkOutput("midRunReset.noDone", doneCount - doneBase, 0);
        rst = 1'b0;

        delayTab[launchNo]     = 7;
        delayTab[launchNo + 1] = 12;
        delayTab[launchNo + 2] = 5;
        delayTab[launchNo + 3] = 9;
        applyStimulus("multi", 8'd4, 1'b0);

        delayTab[launchNo] = 10;
        applyStimulus("single", 8'd1, 1'b0);

        presetVal = 32'hFFFF_FFFA - SETTLE_CYC;
        presetReq = 1'b1;
        tick();
        presetReq = 1'b0;
        delayTab[launchNo] = 10;
        applyStimulus("wrap", 8'd1, 1'b0);

        delayTab[launchNo]     = 8;
        delayTab[launchNo + 1] = 0;
        delayTab[launchNo + 2] = 6;
        applyStimulus("timeout", 8'd3, 1'b0);
        checkOutput("timeout.lastAfterSample2", lastAtIdx2, 64'hFFFF_FFFF);

        delayTab[launchNo]     = 13;
        delayTab[launchNo + 1] = 4;
        applyStimulus("startHeld", 8'd2, 1'b1);

        delayTab[launchNo]     = 9;
        delayTab[launchNo + 1] = 11;
        applyStimulus("zeroSamples", 8'd0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                delayTab[launchNo + i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, 40);
            applyStimulus($sformatf("random%0d", r), SAMP_W'(n), 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/delay_measure_ctrl.md
Name: delay_measure_ctrl

Overview:
Measurement controller for the delay datapath. It launches a transition into the delay path under test by driving the datapath's path input. It reads the datapath's free-running 32-bit cycle counter at launch and again when the transition returns on the path result. It repeats this for a programmable number of samples and reports the last, minimum, maximum and summed delay in clock cycles to the spy readout logic.

Parameters:
CNT_W, 32, width of the datapath counter and of all count outputs.
SYNC_STAGES, 2, flip-flop synchronizer depth on the asynchronous path_result input (minimum 2).
SETTLE_CYC, 16, idle cycles between samples so the path fully settles.
TIMEOUT_CYC, 1000000, elapsed cycles after launch at which a sample is abandoned.
SAMP_W, 8, width of the sample-count and sample-index fields.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous and active-high
start  in  1  begin a measurement run; sampled only in IDLE
num_samples  in  SAMP_W  samples per run; 0 is treated as 1
count_in  in  CNT_W  datapath counter value (registered in the datapath)
path_result  in  1  delay-path output; asynchronous to clk
path_in  out  1  drives the datapath path input
ld  out  1  datapath counter enable
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at the end of a run
timeout  out  1  sticky; set if any sample timed out; cleared on an accepted start
last_count  out  CNT_W  most recent sample delay
min_count  out  CNT_W  minimum delay over valid samples in the run
max_count  out  CNT_W  maximum delay over valid samples in the run
sum_count  out  CNT_W+SAMP_W  sum of valid sample delays
sample_idx  out  SAMP_W  number of samples completed in the current run

Behaviour:
- Reset values (when rst=1):
  - path_in=0, ld=0, busy=0, done=0, timeout=0, sample_idx=0.
  - last_count, max_count and sum_count = 0; min_count = all ones.
  - FSM goes to IDLE; synchronizer flops are cleared.
  - rst mid-run aborts the run immediately, with no done pulse.
- Synchronizer: path_result passes through SYNC_STAGES flops to give rs. Only rs is used internally.
- ld is 1 in every state except IDLE, so the counter free-runs during a run. The counter is never cleared; all delays are modular differences.
- FSM states:
  - IDLE: when start=1, clear the stats, sample_idx and timeout, latch num_samples (0 becomes 1), then go to SETTLE. start pulses while busy are ignored.
  - SETTLE: count SETTLE_CYC cycles. On the last cycle, capture baseline = rs, then go to LAUNCH.
  - LAUNCH (1 cycle): toggle path_in, capture t0 = count_in, clear the elapsed counter, then go to WAIT.
  - WAIT: elapsed increments each cycle.
    - If rs != baseline: capture t1 = count_in and go to RECORD.
    - Else, if elapsed == TIMEOUT_CYC: set timeout and go to RECORD with the sample marked invalid.
    - If both hold in the same cycle, the arrival wins.
  - RECORD (1 cycle):
    - For a valid sample: d = (t1 - t0) mod 2^CNT_W, minus SYNC_STAGES, saturating at 0. Set last_count = d, min_count = min(min_count, d), max_count = max(max_count, d), sum_count += d.
    - For an invalid sample: stats are unchanged and last_count = all ones.
    - sample_idx increments in both cases. If sample_idx reaches the latched count, go to DONE; otherwise go to SETTLE.
  - DONE (1 cycle): done=1, then go to IDLE. Outputs hold until the next accepted start.
- path_in is not restored between samples. Each launch is a toggle, so rising and falling path transitions alternate.
- Counter wrap: modular subtraction gives the correct delay across 0xFFFFFFFF -> 0.
- sum_count has no overflow, since it is CNT_W+SAMP_W bits wide.

Test Plan:
- Reset: hold rst for 3 cycles mid-WAIT -> all outputs at their reset values, path_in=0, no done pulse; start is accepted 1 cycle after rst falls.
- Single sample: num_samples=1, model path_result toggling 10 cycles after path_in (counter model +1 per cycle with ld=1) -> last_count = min_count = max_count = sum_count = 10 (observed span 10+2 minus SYNC_STAGES), done pulses once, sample_idx=1.
- Multi-sample: num_samples=4, path delays 7, 12, 5, 9 -> min=5, max=12, sum=33, path_in toggles 4 times and ends at 0.
- Wrap: counter preset to 0xFFFFFFFA, delay 10 -> last_count = 10.
- Timeout: TIMEOUT_CYC=50, path never responds on sample 2 of 3 with delays 8 and 6 on the other two -> timeout=1, last_count is all ones after sample 2, min=6, max=8, sum=14, sample_idx=3.
- Control corners: start held high during a whole run -> exactly one run; num_samples=0 -> exactly one sample taken.
